// File: rtl/mips_io_bridge_pkg.sv
// Shared constants and types for the MIPS I/O bridge.
// UART_PARITY_EN adds the even-parity state to the tx enumeration.
package mips_io_bridge_pkg;

  localparam logic [7:0] RAM_TOP      = 8'hFB;
  localparam logic [7:0] ADR_GPIO_OUT = 8'hFC;
  localparam logic [7:0] ADR_TX_DATA  = 8'hFD;
  localparam logic [7:0] ADR_STATUS   = 8'hFE;
  localparam logic [7:0] ADR_GPIO_IN  = 8'hFF;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_OCC   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/mips_io_bridge_fifo.sv
// Four-entry byte FIFO feeding the UART transmitter.
// A push is accepted when full only if a pop happens on the same edge.
module uart_tx_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_io_bridge.sv
// Memory-mapped RAM/GPIO/UART-tx bridge for a small MIPS core.
// Define UART_PARITY_EN for 8E1 frames; default is 8N1.
module mips_io_bridge
  import mips_io_bridge_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int BAUD_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             memread,
  input  logic             memwrite,
  output logic [WIDTH-1:0] memdata,
  output logic             ram_we,
  input  logic [WIDTH-1:0] ram_rdata,
  input  logic [7:0]       gpio_in,
  output logic [7:0]       gpio_out,
  output logic             tx
);

  localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);

  logic       is_ram, hit_gout, hit_tx, hit_st, hit_gin;
  logic [7:0] gin_s1, gin_s2;
  logic       overflow;
  logic [7:0] status;
  logic       push_req, pop;
  logic [7:0] fifo_dout;
  logic       fifo_full, fifo_empty;
  logic [2:0] fifo_count;

  tx_state_e  state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shreg, sh_n;
`ifdef UART_PARITY_EN
  logic       par, par_n;
`endif

  assign is_ram   = adr <= WIDTH'(RAM_TOP);
  assign hit_gout = adr == WIDTH'(ADR_GPIO_OUT);
  assign hit_tx   = adr == WIDTH'(ADR_TX_DATA);
  assign hit_st   = adr == WIDTH'(ADR_STATUS);
  assign hit_gin  = adr == WIDTH'(ADR_GPIO_IN);

  assign ram_we   = memwrite && is_ram;
  assign push_req = memwrite && hit_tx;

  always_comb begin
    status               = '0;
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_BUSY]      = (state != S_IDLE);
    status[ST_OVF]       = overflow;
    status[ST_OCC +: 2]  = fifo_count[1:0];
  end

  always_comb begin
    memdata = '0;
    unique case (1'b1)
      is_ram:   memdata      = ram_rdata;
      hit_gout: memdata[7:0] = gpio_out;
      hit_st:   memdata[7:0] = status;
      hit_gin:  memdata[7:0] = gin_s2;
      default:  memdata      = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= '0;
      gin_s1   <= '0;
      gin_s2   <= '0;
      overflow <= 1'b0;
    end else begin
      gin_s1 <= gpio_in;
      gin_s2 <= gin_s1;
      if (memwrite && hit_gout) gpio_out <= writedata[7:0];
      if (memwrite && hit_st)
        overflow <= 1'b0;
      else if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  uart_tx_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
`ifdef UART_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Every non-idle state holds for BAUD_DIV cycles, then reloads.
  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    sh_n    = shreg;
    pop     = 1'b0;
    cnt_n   = (cnt == 8'd0) ? BAUD_LAST : cnt - 8'd1;
`ifdef UART_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          bit_n   = '0;
          cnt_n   = BAUD_LAST;
          state_n = S_START;
`ifdef UART_PARITY_EN
          par_n   = ^fifo_dout;
`endif
        end
      end
      S_START: if (cnt == 8'd0) state_n = S_DATA;
      S_DATA: begin
        if (cnt == 8'd0) begin
          sh_n  = shreg >> 1;
          bit_n = bit_idx + 3'd1;
`ifdef UART_PARITY_EN
          if (bit_idx == 3'd7) state_n = S_PARITY;
`else
          if (bit_idx == 3'd7) state_n = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: if (cnt == 8'd0) state_n = S_STOP;
`endif
      S_STOP: begin
        if (cnt == 8'd0) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = shreg[0];
`ifdef UART_PARITY_EN
      S_PARITY: tx = par;
`endif
      default:  tx = 1'b1;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{memread, fifo_count[2], writedata};

endmodule

// File: tb/tb_mips_io_bridge.sv
// Scoreboard bench for mips_io_bridge: bus checks plus a serial
// frame monitor that decodes tx against queued expected bytes.
module tb_mips_io_bridge;

  localparam int BD = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] adr = '0;
  logic [7:0] writedata = '0;
  logic       memread = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] ram_rdata = '0;
  logic [7:0] gpio_in = '0;
  logic [7:0] memdata;
  logic       ram_we;
  logic [7:0] gpio_out;
  logic       tx;

  int checks = 0;
  int errors = 0;

  int         sel_q[$];
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic [7:0] tx_q[$];

  mips_io_bridge #(.WIDTH(8), .BAUD_DIV(BD)) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // sel: 0 memdata, 1 ram_we, 2 tx, 3 gpio_out
  task automatic expect_v(int sel, logic [7:0] v, string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : bus_mon
    int         s;
    logic [7:0] e, a;
    string      n;
    while (sel_q.size() > 0) begin
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (s)
        0:       a = memdata;
        1:       a = {7'b0, ram_we};
        2:       a = {7'b0, tx};
        default: a = gpio_out;
      endcase
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got %h want %h", n, a, e);
      end
    end
  end

  function automatic logic fbit(int k, logic [7:0] d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  initial begin : ser_mon
    logic [63:0] ev, av;
    logic [7:0]  b;
    bit          ab, unexp;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      ev = '0;
      av = '0;
      ab = 1'b0;
      unexp = 1'b0;
      b = '0;
      if (tx_q.size() == 0) begin
        unexp = 1'b1;
        checks++;
        errors++;
        $display("FAIL frame_unexpected got start bit want idle");
      end else begin
        b = tx_q.pop_front();
      end
      for (int k = 0; k < NB; k++)
        for (int c = 0; c < BD; c++)
          ev[k*BD+c] = fbit(k, b);
      av[0] = tx;
      for (int i = 1; i < NB*BD; i++) begin
        @(negedge clk);
        if (reset !== 1'b0) begin
          ab = 1'b1;
          break;
        end
        av[i] = tx;
      end
      if (!ab && !unexp) begin
        checks++;
        if (av !== ev) begin
          errors++;
          $display("FAIL frame_%h got %h want %h", b, av, ev);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [7:0] a, logic [7:0] e, string nm);
    adr = a;
    memwrite = 1'b0;
    memread = 1'b1;
    expect_v(0, e, nm);
    cyc();
    memread = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [7:0] d);
    adr = a;
    writedata = d;
    memwrite = 1'b1;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic wr_we(logic [7:0] a, logic [7:0] d,
                       logic we, string nm);
    expect_v(1, {7'b0, we}, nm);
    wr(a, d);
  endtask

  task automatic wait_idle(int budget, string nm);
    int n = 0;
    adr = 8'hFE;
    memwrite = 1'b0;
    #1;
    while (memdata !== 8'h02 && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s got status %h want 02 in %0d cyc",
               nm, memdata, budget);
    end
  endtask

  task automatic check_drained(string nm);
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s got %0d pending frames want 0",
               nm, tx_q.size());
    end
  endtask

  initial begin : stim
    int  n;
    bit  done;
    repeat (3) cyc();
    reset = 1'b0;

    adr = 8'hFE;
    expect_v(0, 8'h02, "rst_status");
    expect_v(2, 8'h01, "rst_tx");
    expect_v(3, 8'h00, "rst_gpio_out");
    expect_v(1, 8'h00, "rst_ram_we");
    cyc();

    wr_we(8'h10, 8'h5A, 1'b1, "ram_we_10");
    wr_we(8'hFB, 8'h11, 1'b1, "ram_we_fb");
    wr_we(8'hFC, 8'hA5, 1'b0, "ram_we_fc");
    ram_rdata = 8'h5A;
    rd(8'h10, 8'h5A, "rd_ram_10");
    ram_rdata = 8'h77;
    rd(8'hFB, 8'h77, "rd_ram_fb");
    rd(8'hFD, 8'h00, "rd_tx_data");
    expect_v(3, 8'hA5, "gpio_out_pin");
    rd(8'hFC, 8'hA5, "rd_gpio_out");

    gpio_in = 8'h3C;
    rd(8'hFF, 8'h00, "gin_c0");
    rd(8'hFF, 8'h00, "gin_c1");
    rd(8'hFF, 8'h3C, "gin_c2");
    wr_we(8'hFF, 8'h00, 1'b0, "ram_we_ff");
    rd(8'hFF, 8'h3C, "gin_readonly");

    tx_q.push_back(8'h55);
    wr(8'hFD, 8'h55);
    rd(8'hFE, 8'h10, "st_one_queued");
    rd(8'hFE, 8'h06, "st_busy");
    wait_idle(60, "frame55_done");
    expect_v(2, 8'h01, "tx_idle_after");
    rd(8'hFE, 8'h02, "st_after_frame");

    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) tx_q.push_back(8'(i));
      wr(8'hFD, 8'(i));
    end
    rd(8'hFE, 8'h0D, "st_overflow");
    wr(8'hFE, 8'h00);
    rd(8'hFE, 8'h05, "st_ovf_clear");

    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      adr = 8'hFE;
      memwrite = 1'b0;
      #1;
      if (memdata[2] == 1'b0) begin
        adr = 8'hFD;
        writedata = 8'h07;
        memwrite = 1'b1;
        tx_q.push_back(8'h07);
        cyc();
        memwrite = 1'b0;
        done = 1'b1;
      end else begin
        cyc();
      end
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL pushpop_wait got busy want idle slot");
    end
    rd(8'hFE, 8'h05, "st_full_pushpop");
    wait_idle(400, "drain_done");
    check_drained("drain_frames");

    tx_q.push_back(8'hF0);
    wr(8'hFD, 8'hF0);
    wr(8'hFD, 8'h33);
    repeat (8) cyc();
    reset = 1'b1;
    tx_q.delete();
    cyc();
    reset = 1'b0;
    adr = 8'hFE;
    expect_v(2, 8'h01, "abort_tx");
    expect_v(0, 8'h02, "abort_status");
    expect_v(3, 8'h00, "abort_gpio_out");
    cyc();

    tx_q.push_back(8'hC3);
    wr(8'hFD, 8'hC3);
    wait_idle(60, "c3_done");
    rd(8'hFE, 8'h02, "st_final");
    check_drained("final_frames");

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_io_bridge.md
MIPS_IO_BRIDGE -- requirements
Module: mips_io_bridge

Interface
REQ-001 Parameter WIDTH, default 8: data and address width of the processor bus.
REQ-002 Parameter BAUD_DIV, default 16: clock cycles per serial bit; legal range 2..255.
REQ-003 clk  in  1: single clock; all state updates on rising edge.
REQ-004 reset  in  1: synchronous, active-high.
REQ-005 adr  in  WIDTH: processor byte address.
REQ-006 writedata  in  WIDTH: processor store data.
REQ-007 memread, memwrite  in  1 each: processor access strobes; each asserted at most one cycle per access.
REQ-008 memdata  out  WIDTH: read data returned to the processor, combinational from adr.
REQ-009 ram_we  out  1: write enable to external RAM; ram_rdata  in  WIDTH: RAM read data (asynchronous read).
REQ-010 gpio_in  in  8: asynchronous input pins; gpio_out  out  8: output register.
REQ-011 tx  out  1: serial transmit line; idle level 1.

Function
REQ-012 Address map SHALL be: 0x00-0xFB RAM; 0xFC GPIO_OUT (R/W); 0xFD TX_DATA (W push, reads 0); 0xFE STATUS (R; any write clears overflow); 0xFF GPIO_IN (R only, writes ignored).
REQ-013 ram_we = memwrite AND adr < 0xFC; memdata = ram_rdata for RAM addresses, else the selected I/O register, zero-extended.
REQ-014 STATUS bits: [0] fifo_full, [1] fifo_empty, [2] tx_busy, [3] overflow (sticky), [5:4] occupancy mod 4, [7:6] 0.
REQ-015 gpio_in SHALL pass a two-flop synchronizer; GPIO_IN reads the second stage (2-cycle latency).
REQ-016 TX FIFO: 4 entries, 2-bit wrapping pointers plus 3-bit count; write to 0xFD when count<4 pushes writedata, visible in STATUS next cycle.
REQ-017 Write to 0xFD when full SHALL drop the data and set overflow; FIFO contents unchanged.
REQ-018 Simultaneous push and pop when full SHALL be accepted (count unchanged, no overflow); push and pop when empty is impossible (pop requires non-empty).
REQ-019 Transmitter FSM states IDLE, START, DATA, PARITY, STOP; each non-IDLE state lasts BAUD_DIV cycles via a down-counter.
REQ-020 IDLE->START when FIFO non-empty: pop head into shift register same edge; tx=0 during START.
REQ-021 DATA sends 8 bits LSB first via a 3-bit bit counter; after bit 7, go to PARITY (macro defined) or STOP.
REQ-022 STOP drives tx=1 for BAUD_DIV cycles then returns to IDLE; a waiting byte starts START on the next cycle (one idle cycle minimum between frames).
REQ-023 tx_busy = (state != IDLE).
REQ-024 Word width greater than 8: only writedata[7:0] queued; GPIO bits above 7 read zero.

Reset
REQ-025 reset SHALL force: gpio_out=0, FIFO empty (pointers and count 0), overflow=0, state IDLE, tx=1, counters 0, synchronizer flops 0.
REQ-026 reset mid-frame SHALL abort the frame; tx is 1 on the cycle after reset is sampled; queued bytes discarded.

Configuration
REQ-027 Macro UART_PARITY_EN defined: PARITY state inserted after DATA, sending even parity (XOR of the 8 data bits), 11-bit frames.
REQ-028 UART_PARITY_EN undefined: PARITY state and its logic absent; 10-bit frames (8N1).

Structure
REQ-029 Shared package holds address constants (RAM_TOP, ADR_GPIO_OUT, ADR_TX_DATA, ADR_STATUS, ADR_GPIO_IN), STATUS bit indices and the tx state enumeration.
REQ-030 One sub-module, uart_tx_fifo (4-entry FIFO with full/empty/count); FSM, decode and GPIO remain in mips_io_bridge.

Verification
REQ-031 Write 0x5A to 0x10 -> ram_we=1 that cycle; read 0x10 with ram_rdata=0x5A -> memdata=0x5A.
REQ-032 Write 0xA5 to 0xFC, read 0xFC -> 0xA5; gpio_in=0x3C -> GPIO_IN reads 0x3C from the 2nd cycle after the change.
REQ-033 BAUD_DIV=4, push 0x55 -> tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high; STATUS[2] clears after stop (+ parity bit 0 with UART_PARITY_EN).
REQ-034 Five back-to-back pushes while transmitter idle -> first byte popped, four queued, fifth dropped only if FIFO full at push time; STATUS[3]=1 on drop; write to 0xFE clears it.
REQ-035 Assert reset during DATA of a frame -> tx=1 next cycle, STATUS reads 0x02, subsequent push transmits normally.
